ts4231_emulator: RTL and testbench

//  Synthesizable responder model of the TS4231 light-to-digital converter's two-wire D/E bus. It lets the

---
 rtl/ts4231_emulator.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_ts4231_emulator.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts4231_emulator.sv
// ----------------------------------------------------------------------------
// ts4231_emulator
//
// Synthesizable responder model of the TS4231 light-to-digital converter's
// two-wire D/E bus. It emulates the sensor states S0, S3, SLEEP and WATCH
// together with the configuration-word write and read frames, so that a host
// configuration FSM can be exercised without a real sensor. The emulator only
// drives weak levels; the surrounding top level resolves each wire as
// host_oe ? host_val : emulator_val and feeds the result back on d_i/e_i.
//
// Ports
//   clk          in   clock
//   rst          in   asynchronous, active-high reset
//   d_i, e_i     in   resolved D/E bus levels (asynchronous to clk)
//   d_w, e_w     out  weak D/E levels driven by the emulator (registered)
//   light_env    in   emulated optical envelope, high = light present
//   light_data   in   emulated optical data
//   force_sleep  in   pulse: S3 or WATCH -> SLEEP
//   emu_state    out  0=SLEEP 1=WATCH 2=S3 3=S0 4=BUSY (any frame state)
//   cfg_value    out  last committed configuration word
//   cfg_valid    out  set by a committed write, cleared only by reset
//   protocol_err out  one-cycle pulse when a frame is aborted
// ----------------------------------------------------------------------------
module ts4231_emulator #(
    parameter int unsigned CLK_SPEED   = 50_000_000, // Hz, informational
    parameter int unsigned TIMEOUT_CYC = 50_000,     // idle cycles before a frame aborts
    parameter logic [13:0] CFG_DEFAULT = 14'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_i,
    input  logic        e_i,
    output logic        d_w,
    output logic        e_w,
    input  logic        light_env,
    input  logic        light_data,
    input  logic        force_sleep,
    output logic [2:0]  emu_state,
    output logic [13:0] cfg_value,
    output logic        cfg_valid,
    output logic        protocol_err
);

    if (TIMEOUT_CYC < 2 || CLK_SPEED == 0) begin : g_bad_params
        $error("ts4231_emulator: TIMEOUT_CYC must be >= 2 and CLK_SPEED non-zero");
    end

    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [2:0] EMU_SLEEP = 3'd0;
    localparam logic [2:0] EMU_WATCH = 3'd1;
    localparam logic [2:0] EMU_S3    = 3'd2;
    localparam logic [2:0] EMU_S0    = 3'd3;
    localparam logic [2:0] EMU_BUSY  = 3'd4;

    typedef enum logic [3:0] {
        ST_S0,
        ST_ENTRY,
        ST_S3,
        ST_START,
        ST_OP,
        ST_WR,
        ST_WR_STOP,
        ST_RD,
        ST_GW1,
        ST_WATCH,
        ST_SLEEP
    } state_t;

    state_t              state_q, state_d;
    logic                d_s1_q, d_s1_d, d_s2_q, d_s2_d, d_prev_q, d_prev_d;
    logic                e_s1_q, e_s1_d, e_s2_q, e_s2_d, e_prev_q, e_prev_d;
    logic [1:0]          entry_cnt_q, entry_cnt_d;
    logic [3:0]          idx_q, idx_d;
    logic [3:0]          presented_q, presented_d;
    logic [13:0]         shift_q, shift_d;
    logic                rd_bit_q, rd_bit_d;
    logic [13:0]         cfg_value_q, cfg_value_d;
    logic                cfg_valid_q, cfg_valid_d;
    logic                protocol_err_q, protocol_err_d;
    logic                d_w_q, d_w_d, e_w_q, e_w_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;

    // Edge events are taken between the second synchronizer stage and the
    // edge register, so the levels used for qualification are d_s2_q/e_s2_q.
    logic d_rise, d_fall, e_rise, e_fall, d_edge, e_edge, both_edges, any_edge;
    logic in_frame, timeout, abort;
    logic [3:0] rd_idx;

    assign d_rise     = d_s2_q & ~d_prev_q;
    assign d_fall     = ~d_s2_q & d_prev_q;
    assign e_rise     = e_s2_q & ~e_prev_q;
    assign e_fall     = ~e_s2_q & e_prev_q;
    assign d_edge     = d_rise | d_fall;
    assign e_edge     = e_rise | e_fall;
    assign both_edges = d_edge & e_edge;
    assign any_edge   = d_edge | e_edge;

    assign in_frame = (state_q == ST_ENTRY) || (state_q == ST_START) || (state_q == ST_OP) ||
                      (state_q == ST_WR)    || (state_q == ST_WR_STOP) || (state_q == ST_RD) ||
                      (state_q == ST_GW1);

    // The idle counter only advances on edge-free frame cycles.
    assign timeout = in_frame && !any_edge && (idle_q == IDLE_W'(TIMEOUT_CYC - 1));
    assign rd_idx  = 4'd13 - presented_q;

    always_comb begin
        // NOTE: every variable gets a default before the case so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        d_s1_d         = d_i;
        d_s2_d         = d_s1_q;
        d_prev_d       = d_s2_q;
        e_s1_d         = e_i;
        e_s2_d         = e_s1_q;
        e_prev_d       = e_s2_q;
        state_d        = state_q;
        entry_cnt_d    = entry_cnt_q;
        idx_d          = idx_q;
        presented_d    = presented_q;
        shift_d        = shift_q;
        rd_bit_d       = rd_bit_q;
        cfg_value_d    = cfg_value_q;
        cfg_valid_d    = cfg_valid_q;
        abort          = 1'b0;
        idle_d         = (in_frame && !any_edge) ? idle_q + 1'b1 : '0;

        // Simultaneous D/E edges or a stalled frame pre-empt any frame action.
        if (in_frame && (both_edges || timeout)) begin
            abort = 1'b1;
        end else begin
            case (state_q)
                ST_S0: begin
                    if (e_rise && !d_edge && !d_s2_q) begin
                        state_d     = ST_ENTRY;
                        entry_cnt_d = 2'd1;
                    end
                end
                ST_ENTRY: begin
                    if (e_rise && !d_s2_q) begin
                        if (entry_cnt_q != 2'd3) entry_cnt_d = entry_cnt_q + 2'd1;
                    end else if (d_rise && e_s2_q && (entry_cnt_q >= 2'd2)) begin
                        state_d     = ST_S3;
                        entry_cnt_d = '0;
                    end
                end
                ST_S3: begin
                    if (force_sleep) begin
                        state_d = ST_SLEEP;
                    end else if (!both_edges) begin
                        if (d_fall && e_s2_q) state_d = ST_START;
                        else if (e_fall && d_s2_q) state_d = ST_GW1;
                    end
                end
                ST_START: begin
                    if (e_fall) state_d = ST_OP;
                end
                ST_OP: begin
                    if (e_rise) begin
                        if (d_s2_q) begin
                            state_d     = ST_RD;
                            presented_d = '0;
                            rd_bit_d    = 1'b1;
                        end else begin
                            state_d = ST_WR;
                            idx_d   = 4'd13;
                        end
                    end
                end
                ST_WR: begin
                    if (e_rise) begin
                        shift_d[idx_q] = d_s2_q;
                        if (idx_q == 4'd0) state_d = ST_WR_STOP;
                        else idx_d = idx_q - 4'd1;
                    end else if (d_rise && e_s2_q) begin
                        abort = 1'b1;
                    end
                end
                ST_WR_STOP: begin
                    // The trailing E rise carries no data and is ignored.
                    if (d_rise && e_s2_q) begin
                        cfg_value_d = shift_q;
                        cfg_valid_d = 1'b1;
                        state_d     = ST_S3;
                    end
                end
                ST_RD: begin
                    if (e_fall && (presented_q < 4'd14)) begin
                        rd_bit_d    = cfg_value_q[rd_idx];
                        presented_d = presented_q + 4'd1;
                    end else if (d_rise && e_s2_q) begin
                        if (presented_q == 4'd14) state_d = ST_S3;
                        else abort = 1'b1;
                    end
                end
                ST_GW1: begin
                    if (e_rise) state_d = ST_WATCH;
                end
                ST_WATCH: begin
                    if (force_sleep) state_d = ST_SLEEP;
                end
                ST_SLEEP: begin
                    if (d_fall && !e_edge && !e_s2_q) state_d = ST_WATCH;
                end
                default: state_d = ST_S0;
            endcase
        end

        if (abort) begin
            state_d     = (state_q == ST_ENTRY) ? ST_S0 : ST_S3;
            shift_d     = '0;
            entry_cnt_d = '0;
        end
        protocol_err_d = abort;

        // Weak levels follow the state the emulator is currently in; they
        // therefore appear one clock after the transition that selects them.
        case (state_q)
            ST_S0, ST_GW1: begin d_w_d = 1'b0;       e_w_d = 1'b0;       end
            ST_SLEEP:      begin d_w_d = 1'b1;       e_w_d = 1'b0;       end
            ST_WATCH:      begin d_w_d = light_data; e_w_d = ~light_env; end
            ST_RD:         begin d_w_d = rd_bit_q;   e_w_d = 1'b1;       end
            default:       begin d_w_d = 1'b1;       e_w_d = 1'b1;       end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_S0;
            d_s1_q         <= 1'b0;
            d_s2_q         <= 1'b0;
            d_prev_q       <= 1'b0;
            e_s1_q         <= 1'b0;
            e_s2_q         <= 1'b0;
            e_prev_q       <= 1'b0;
            entry_cnt_q    <= '0;
            idx_q          <= '0;
            presented_q    <= '0;
            shift_q        <= '0;
            rd_bit_q       <= 1'b1;
            cfg_value_q    <= CFG_DEFAULT;
            cfg_valid_q    <= 1'b0;
            protocol_err_q <= 1'b0;
            d_w_q          <= 1'b0;
            e_w_q          <= 1'b0;
            idle_q         <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // present before this edge, independent of statement order.
            state_q        <= state_d;
            d_s1_q         <= d_s1_d;
            d_s2_q         <= d_s2_d;
            d_prev_q       <= d_prev_d;
            e_s1_q         <= e_s1_d;
            e_s2_q         <= e_s2_d;
            e_prev_q       <= e_prev_d;
            entry_cnt_q    <= entry_cnt_d;
            idx_q          <= idx_d;
            presented_q    <= presented_d;
            shift_q        <= shift_d;
            rd_bit_q       <= rd_bit_d;
            cfg_value_q    <= cfg_value_d;
            cfg_valid_q    <= cfg_valid_d;
            protocol_err_q <= protocol_err_d;
            d_w_q          <= d_w_d;
            e_w_q          <= e_w_d;
            idle_q         <= idle_d;
        end
    end

    always_comb begin
        case (state_q)
            ST_S0:    emu_state = EMU_S0;
            ST_S3:    emu_state = EMU_S3;
            ST_WATCH: emu_state = EMU_WATCH;
            ST_SLEEP: emu_state = EMU_SLEEP;
            default:  emu_state = EMU_BUSY;
        endcase
    end

    assign d_w          = d_w_q;
    assign e_w          = e_w_q;
    assign cfg_value    = cfg_value_q;
    assign cfg_valid    = cfg_valid_q;
    assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_ts4231_emulator.sv
// ----------------------------------------------------------------------------
// tb_ts4231_emulator
//
// Directed bench for ts4231_emulator. A host model drives the D/E bus (the
// resolved level is host_oe ? host : emulator). Every time the observable
// output tuple {emu_state, d_w, e_w, cfg_value, cfg_valid} changes, a monitor
// pops the next expected tuple (and whether protocol_err pulsed with it) from
// a scoreboard queue filled by the stimulus. Host read-back words are
// compared against expected words the same way.
// ----------------------------------------------------------------------------
module tb_ts4231_emulator;

    localparam int unsigned TO_CYC = 400;
    localparam int          STEP   = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_d, host_e, host_d_oe;
    logic        d_bus, e_bus;
    logic        d_w, e_w;
    logic        light_env, light_data, force_sleep;
    logic [2:0]  emu_state;
    logic [13:0] cfg_value;
    logic        cfg_valid, protocol_err;

    assign d_bus = host_d_oe ? host_d : d_w;
    assign e_bus = host_e;

    always #5 clk = ~clk;

    ts4231_emulator #(
        .CLK_SPEED   (100_000_000),
        .TIMEOUT_CYC (TO_CYC),
        .CFG_DEFAULT (14'h0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .d_i          (d_bus),
        .e_i          (e_bus),
        .d_w          (d_w),
        .e_w          (e_w),
        .light_env    (light_env),
        .light_data   (light_data),
        .force_sleep  (force_sleep),
        .emu_state    (emu_state),
        .cfg_value    (cfg_value),
        .cfg_valid    (cfg_valid),
        .protocol_err (protocol_err)
    );

    typedef struct packed {
        logic [2:0]  st;
        logic        dw;
        logic        ew;
        logic [13:0] val;
        logic        vld;
    } obs_t;

    obs_t        exp_q[$];
    logic        exp_err_q[$];
    string       name_q[$];
    logic [13:0] rd_exp_q[$];
    logic [13:0] rd_obs_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Bench-side model of the committed configuration.
    logic [13:0] cfg_m;
    logic        vld_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input string name, input logic [2:0] st, input logic dw,
                             input logic ew, input logic err);
        obs_t o;
        o.st  = st;
        o.dw  = dw;
        o.ew  = ew;
        o.val = cfg_m;
        o.vld = vld_m;
        exp_q.push_back(o);
        exp_err_q.push_back(err);
        name_q.push_back(name);
    endtask

    function automatic obs_t sample_obs();
        return {emu_state, d_w, e_w, cfg_value, cfg_valid};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        obs_t  last, cur, e;
        logic  err_seen, e_err;
        string nm;
        last = 'x;
        @(negedge clk);
        wait (rst == 1'b0);
        forever begin
            @(negedge clk);
            cur = sample_obs();
            if (cur !== last) begin
                err_seen = protocol_err;
                @(negedge clk);
                cur = sample_obs();
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_change: actual st=%0d dw=%0b ew=%0b val=%0h vld=%0b, required no change",
                             cur.st, cur.dw, cur.ew, cur.val, cur.vld);
                end else begin
                    e     = exp_q.pop_front();
                    e_err = exp_err_q.pop_front();
                    nm    = name_q.pop_front();
                    check({nm, ".emu_state"},    cur.st,   e.st);
                    check({nm, ".d_w"},          cur.dw,   e.dw);
                    check({nm, ".e_w"},          cur.ew,   e.ew);
                    check({nm, ".cfg_value"},    cur.val,  e.val);
                    check({nm, ".cfg_valid"},    cur.vld,  e.vld);
                    check({nm, ".protocol_err"}, err_seen, e_err);
                end
                last = cur;
            end else if (protocol_err) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_protocol_err: actual=1 required=0 (st=%0d)", cur.st);
            end
            if (rd_obs_q.size() != 0 && rd_exp_q.size() != 0)
                check("read_word", rd_obs_q.pop_front(), rd_exp_q.pop_front());
        end
    end

    // ---------------- host bus helpers ----------------
    task automatic step();
        repeat (STEP) @(negedge clk);
    endtask

    task automatic set_d(input logic v);
        host_d = v;
        step();
    endtask

    task automatic set_e(input logic v);
        host_e = v;
        step();
    endtask

    task automatic pulse_sleep();
        force_sleep = 1'b1;
        @(negedge clk);
        force_sleep = 1'b0;
        step();
    endtask

    // From S0 with D=0,E=0: two E rises then D rise -> S3 (D=1,E=1 after).
    task automatic enter_s3();
        expect_ev("entry", 3'd4, 1'b1, 1'b1, 1'b0);
        set_e(1'b1);
        set_e(1'b0);
        set_e(1'b1);
        expect_ev("entry_s3", 3'd2, 1'b1, 1'b1, 1'b0);
        set_d(1'b1);
    endtask

    // From S3 with D=1,E=1: D fall, E fall, opcode on D, E rise.
    task automatic frame_start(input logic opcode, input string name);
        expect_ev(name, 3'd4, 1'b1, 1'b1, 1'b0);
        set_d(1'b0);
        set_e(1'b0);
        set_d(opcode);
        set_e(1'b1);
    endtask

    task automatic send_bits(input logic [13:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            set_e(1'b0);
            set_d(w[13-i]);
            set_e(1'b1);
        end
    endtask

    task automatic write_word(input logic [13:0] w);
        frame_start(1'b0, "wr_start");
        send_bits(w, 14);
        pulse_sleep();             // ignored inside a frame
        set_e(1'b0);
        set_d(1'b0);
        set_e(1'b1);               // extra E rise, ignored
        cfg_m = w;
        vld_m = 1'b1;
        expect_ev("wr_commit", 3'd2, 1'b1, 1'b1, 1'b0);
        set_d(1'b1);
    endtask

    task automatic read_word(input logic [13:0] w);
        logic        prev;
        logic [13:0] got;
        rd_exp_q.push_back(w);
        frame_start(1'b1, "rd_start");
        host_d_oe = 1'b0;
        step();
        prev = 1'b1;
        got  = '0;
        for (int i = 13; i >= 0; i--) begin
            if (w[i] != prev) expect_ev("rd_bit", 3'd4, w[i], 1'b1, 1'b0);
            prev = w[i];
            set_e(1'b0);
            set_e(1'b1);
            got[i] = d_bus;
        end
        rd_obs_q.push_back(got);
        host_d    = 1'b0;
        host_d_oe = 1'b1;
        step();
        expect_ev("rd_stop", 3'd2, 1'b1, 1'b1, 1'b0);
        set_d(1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stimulus
        rst         = 1'b1;
        host_d      = 1'b0;
        host_e      = 1'b0;
        host_d_oe   = 1'b1;
        light_env   = 1'b0;
        light_data  = 1'b0;
        force_sleep = 1'b0;
        cfg_m       = 14'h0000;
        vld_m       = 1'b0;

        expect_ev("reset", 3'd3, 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        step();

        pulse_sleep();                      // ignored in S0
        enter_s3();

        write_word(14'h392B);
        read_word(14'h392B);

        // Partial write then idle -> timeout abort, config unchanged.
        frame_start(1'b0, "to_start");
        send_bits(14'h2AA0, 10);
        expect_ev("timeout_abort", 3'd2, 1'b1, 1'b1, 1'b1);
        repeat (TO_CYC + 50) @(negedge clk);
        set_d(1'b1);                        // D rise in S3, ignored

        // Simultaneous D and E edges inside a frame -> abort.
        expect_ev("sim_start", 3'd4, 1'b1, 1'b1, 1'b0);
        set_d(1'b0);
        set_e(1'b0);
        expect_ev("sim_abort", 3'd2, 1'b1, 1'b1, 1'b1);
        host_d = 1'b1;
        host_e = 1'b1;
        step();

        // Reset in the middle of a write frame.
        frame_start(1'b0, "rst_start");
        send_bits(14'h3FFF, 3);
        cfg_m = 14'h0000;
        vld_m = 1'b0;
        expect_ev("rst_mid", 3'd3, 1'b0, 1'b0, 1'b0);
        rst    = 1'b1;
        host_d = 1'b0;
        host_e = 1'b0;
        step();
        rst = 1'b0;
        step();

        enter_s3();

        // S3 -> GW1 -> WATCH, light levels, SLEEP and wake-up.
        expect_ev("gw1", 3'd4, 1'b0, 1'b0, 1'b0);
        set_e(1'b0);
        set_d(1'b0);                        // D edge in GW1, ignored
        expect_ev("watch", 3'd1, 1'b0, 1'b1, 1'b0);
        set_e(1'b1);
        expect_ev("watch_env", 3'd1, 1'b0, 1'b0, 1'b0);
        light_env = 1'b1;
        step();
        expect_ev("watch_data", 3'd1, 1'b1, 1'b0, 1'b0);
        light_data = 1'b1;
        step();
        expect_ev("sleep", 3'd0, 1'b1, 1'b0, 1'b0);
        pulse_sleep();
        set_d(1'b1);                        // ignored in SLEEP
        set_e(1'b0);                        // ignored in SLEEP
        expect_ev("wake", 3'd1, 1'b1, 1'b0, 1'b0);
        set_d(1'b0);
        expect_ev("watch_dark", 3'd1, 1'b1, 1'b1, 1'b0);
        light_env = 1'b0;
        step();

        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        check("expect_queue_drained", exp_q.size(), 0);
        check("read_queue_drained", rd_exp_q.size() + rd_obs_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #600_000;
        $display("FAIL watchdog: simulation did not reach the end of the test");
        $fatal(1, "watchdog expired");
    end

endmodule
